// File: rtl/ex_pkg.sv
// rtl/ex_pkg.sv - operation encodings, MDU state type and helpers for the execute stage
package ex_pkg;

  localparam int ALUOP_W = 5;

  localparam logic [ALUOP_W-1:0] OP_ADD   = 5'd0;
  localparam logic [ALUOP_W-1:0] OP_SUB   = 5'd1;
  localparam logic [ALUOP_W-1:0] OP_AND   = 5'd2;
  localparam logic [ALUOP_W-1:0] OP_OR    = 5'd3;
  localparam logic [ALUOP_W-1:0] OP_XOR   = 5'd4;
  localparam logic [ALUOP_W-1:0] OP_SLL   = 5'd5;
  localparam logic [ALUOP_W-1:0] OP_SRL   = 5'd6;
  localparam logic [ALUOP_W-1:0] OP_SRA   = 5'd7;
  localparam logic [ALUOP_W-1:0] OP_SLT   = 5'd8;
  localparam logic [ALUOP_W-1:0] OP_SLTU  = 5'd9;
  localparam logic [ALUOP_W-1:0] OP_LUI   = 5'd10;
  localparam logic [ALUOP_W-1:0] OP_AUIPC = 5'd11;
  localparam logic [ALUOP_W-1:0] OP_MUL   = 5'd16;
  localparam logic [ALUOP_W-1:0] OP_MULH  = 5'd17;
  localparam logic [ALUOP_W-1:0] OP_MULHU = 5'd18;
  localparam logic [ALUOP_W-1:0] OP_DIV   = 5'd20;
  localparam logic [ALUOP_W-1:0] OP_DIVU  = 5'd21;
  localparam logic [ALUOP_W-1:0] OP_REM   = 5'd22;
  localparam logic [ALUOP_W-1:0] OP_REMU  = 5'd23;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } mdu_state_t;

  function automatic logic is_mdu(input logic [ALUOP_W-1:0] op);
    return op[4];
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - radix-2 iterative multiply/divide: FSM, iteration counter and datapath
module mdu_iter #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         flush,
  input  logic [ex_pkg::ALUOP_W-1:0]   op,
  input  logic [XLEN-1:0]              a,
  input  logic [XLEN-1:0]              b,
  output logic                         busy,
  output logic                         iterating,
  output logic                         done,
  output logic [XLEN-1:0]              result
);
  import ex_pkg::*;

  mdu_state_t                state;
  logic [CNT_W-1:0]          cnt;
  logic [ALUOP_W-1:0]        op_r;
  logic [XLEN-1:0]           mcand;
  logic [2*XLEN-1:0]         acc;
  logic                      neg_q;
  logic                      neg_r;
  logic                      spec;
  logic [XLEN-1:0]           spec_res;

  logic                      sgn_op, is_mul_op, is_div_op;
  logic                      a_neg, b_neg, div0, ovf, spec_hit;
  logic [XLEN-1:0]           a_mag, b_mag, spec_val;
  logic [XLEN:0]             mul_sum;
  logic [XLEN:0]             div_shift;
  logic [XLEN-1:0]           div_diff;
  logic                      div_ok;
  logic [2*XLEN-1:0]         prod;
  logic [XLEN-1:0]           quo, rem;

  // Operand preparation: magnitudes plus sign flags, and the divide corner cases
  always_comb begin
    sgn_op    = (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    is_mul_op = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHU);
    is_div_op = (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
    a_neg     = sgn_op && a[XLEN-1];
    b_neg     = sgn_op && b[XLEN-1];
    a_mag     = a_neg ? -a : a;
    b_mag     = b_neg ? -b : b;
    div0      = is_div_op && (b == '0);
    ovf       = ((op == OP_DIV) || (op == OP_REM)) &&
                (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    spec_hit  = !(is_mul_op || is_div_op) || div0 || ovf;
    spec_val  = '0;
    if (div0)
      spec_val = ((op == OP_DIV) || (op == OP_DIVU)) ? '1 : a;
    else if (ovf)
      spec_val = (op == OP_DIV) ? a : '0;
  end

  // One iteration step; the divider keeps remainder in acc high and quotient in acc low
  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mcand} : '0);
    div_shift = acc[2*XLEN-1:XLEN-1];
    div_ok    = div_shift >= {1'b0, mcand};
    div_diff  = XLEN'(div_shift - {1'b0, mcand});
  end

  always_comb begin
    prod   = neg_q ? -acc : acc;
    quo    = acc[XLEN-1:0];
    rem    = acc[2*XLEN-1:XLEN];
    result = '0;
    if (spec)
      result = spec_res;
    else begin
      case (op_r)
        OP_MUL:             result = prod[XLEN-1:0];
        OP_MULH, OP_MULHU:  result = prod[2*XLEN-1:XLEN];
        OP_DIV, OP_DIVU:    result = neg_q ? -quo : quo;
        OP_REM, OP_REMU:    result = neg_r ? -rem : rem;
        default:            result = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      op_r     <= '0;
      mcand    <= '0;
      acc      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      spec     <= 1'b0;
      spec_res <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_r     <= op;
            mcand    <= b_mag;
            acc      <= {{XLEN{1'b0}}, a_mag};
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            spec     <= spec_hit;
            spec_res <= spec_val;
            if (spec_hit) begin
              cnt   <= '0;
              state <= ST_FIX;
            end else begin
              cnt   <= CNT_W'(XLEN);
              state <= is_mul_op ? ST_MUL : ST_DIV;
            end
          end
        end
        ST_MUL, ST_DIV: begin
          if (flush) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end else begin
            if (state == ST_MUL)
              acc <= {mul_sum, acc[XLEN-1:1]};
            else if (div_ok)
              acc <= {div_diff, acc[XLEN-2:0], 1'b1};
            else
              acc <= {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1))
              state <= ST_FIX;
          end
        end
        ST_FIX: begin
          cnt   <= '0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = (state != ST_IDLE);
  assign iterating = (state == ST_MUL) || (state == ST_DIV);
  assign done      = (state == ST_FIX) && !flush;

endmodule

// File: rtl/ex_stage_mdu.sv
// rtl/ex_stage_mdu.sv - execute stage: single-cycle ALU, iterative MDU and EX/MEM result register
module ex_stage_mdu #(
  parameter int XLEN    = 32,
  parameter int ALUOP_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ex_valid,
  input  logic [XLEN-1:0]    ex_pc,
  input  logic [XLEN-1:0]    fwd_a,
  input  logic [XLEN-1:0]    fwd_b,
  input  logic [ALUOP_W-1:0] ex_aluop,
  input  logic               flush,
  output logic               ex_stall,
  output logic               out_valid,
  output logic [XLEN-1:0]    out_aluout,
  output logic               out_zero,
  output logic               mdu_busy
);
  import ex_pkg::*;

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam int SH_W  = $clog2(XLEN);

  logic            op_mdu;
  logic            accept;
  logic            alu_fire;
  logic            mdu_iterating;
  logic            mdu_done;
  logic [XLEN-1:0] mdu_result;
  logic [XLEN-1:0] alu_res;
  logic [SH_W-1:0] shamt;

  assign op_mdu   = is_mdu(ex_aluop[4:0]);
  assign accept   = !mdu_busy && ex_valid && !flush;
  assign alu_fire = accept && !op_mdu;
  assign shamt    = fwd_b[SH_W-1:0];

  // Flush releases the stall in the same cycle so the redirect is not held off
  assign ex_stall = (accept && op_mdu) || (mdu_iterating && !flush);

  always_comb begin
    alu_res = '0;
    case (ex_aluop[4:0])
      OP_ADD:   alu_res = fwd_a + fwd_b;
      OP_SUB:   alu_res = fwd_a - fwd_b;
      OP_AND:   alu_res = fwd_a & fwd_b;
      OP_OR:    alu_res = fwd_a | fwd_b;
      OP_XOR:   alu_res = fwd_a ^ fwd_b;
      OP_SLL:   alu_res = fwd_a << shamt;
      OP_SRL:   alu_res = fwd_a >> shamt;
      OP_SRA:   alu_res = $signed(fwd_a) >>> shamt;
      OP_SLT:   alu_res = {{(XLEN-1){1'b0}}, $signed(fwd_a) < $signed(fwd_b)};
      OP_SLTU:  alu_res = {{(XLEN-1){1'b0}}, fwd_a < fwd_b};
      OP_LUI:   alu_res = fwd_b;
      OP_AUIPC: alu_res = ex_pc + fwd_b;
      default:  alu_res = '0;
    endcase
  end

  mdu_iter #(
    .XLEN  (XLEN),
    .CNT_W (CNT_W)
  ) u_mdu_iter (
    .clk       (clk),
    .rst       (rst),
    .start     (accept && op_mdu),
    .flush     (flush),
    .op        (ex_aluop[4:0]),
    .a         (fwd_a),
    .b         (fwd_b),
    .busy      (mdu_busy),
    .iterating (mdu_iterating),
    .done      (mdu_done),
    .result    (mdu_result)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_aluout <= '0;
      out_zero   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (mdu_done) begin
        out_valid  <= 1'b1;
        out_aluout <= mdu_result;
        out_zero   <= (mdu_result == '0);
      end else if (alu_fire) begin
        out_valid  <= 1'b1;
        out_aluout <= alu_res;
        out_zero   <= (alu_res == '0);
      end
    end
  end

endmodule

// File: tb/tb_ex_stage_mdu.sv
// tb/tb_ex_stage_mdu.sv - directed vector bench for ex_stage_mdu
module tb_ex_stage_mdu;
  import ex_pkg::*;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [31:0] fwd_a;
  logic [31:0] fwd_b;
  logic [4:0]  ex_aluop;
  logic        flush;
  logic        ex_stall;
  logic        out_valid;
  logic [31:0] out_aluout;
  logic        out_zero;
  logic        mdu_busy;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pc;
    logic [31:0] exp;
  } alu_vec_t;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    int          stalls;
  } mdu_vec_t;

  alu_vec_t alu_v[13];
  mdu_vec_t mdu_v[14];

  ex_stage_mdu #(.XLEN(32), .ALUOP_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .ex_valid   (ex_valid),
    .ex_pc      (ex_pc),
    .fwd_a      (fwd_a),
    .fwd_b      (fwd_b),
    .ex_aluop   (ex_aluop),
    .flush      (flush),
    .ex_stall   (ex_stall),
    .out_valid  (out_valid),
    .out_aluout (out_aluout),
    .out_zero   (out_zero),
    .mdu_busy   (mdu_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_mdu(input string name, input mdu_vec_t v);
    int lat;
    int stalls;
    ex_valid = 1'b1;
    ex_aluop = v.op;
    fwd_a    = v.a;
    fwd_b    = v.b;
    #1;
    chk({name, " accept stall"}, 32'(ex_stall), 32'd1);
    tick();
    ex_valid = 1'b0;
    lat      = 0;
    stalls   = 0;
    while (lat < 40) begin
      if (ex_stall) stalls++;
      tick();
      lat++;
      if (out_valid) break;
    end
    chk({name, " latency"}, 32'(lat), 32'(v.lat));
    chk({name, " stall cycles"}, 32'(stalls), 32'(v.stalls));
    chk({name, " result"}, out_aluout, v.exp);
    chk({name, " zero"}, 32'(out_zero), 32'(v.exp == 32'd0));
    tick();
    chk({name, " valid drop"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    alu_v[0]  = '{OP_ADD,   32'h7FFFFFFF, 32'h00000001, 32'h0,      32'h80000000};
    alu_v[1]  = '{OP_SUB,   32'h00000005, 32'h00000005, 32'h0,      32'h00000000};
    alu_v[2]  = '{OP_AND,   32'hF0F0F0F0, 32'h0FF00FF0, 32'h0,      32'h00F000F0};
    alu_v[3]  = '{OP_OR,    32'hF0000000, 32'h0000000F, 32'h0,      32'hF000000F};
    alu_v[4]  = '{OP_XOR,   32'hFFFF0000, 32'hFF00FF00, 32'h0,      32'h00FFFF00};
    alu_v[5]  = '{OP_SLL,   32'h00000001, 32'h00000024, 32'h0,      32'h00000010};
    alu_v[6]  = '{OP_SRL,   32'h80000000, 32'h0000001F, 32'h0,      32'h00000001};
    alu_v[7]  = '{OP_SRA,   32'h80000000, 32'h00000004, 32'h0,      32'hF8000000};
    alu_v[8]  = '{OP_SLT,   32'hFFFFFFFF, 32'h00000001, 32'h0,      32'h00000001};
    alu_v[9]  = '{OP_SLTU,  32'hFFFFFFFF, 32'h00000001, 32'h0,      32'h00000000};
    alu_v[10] = '{OP_LUI,   32'hDEADBEEF, 32'h12345000, 32'h0,      32'h12345000};
    alu_v[11] = '{OP_AUIPC, 32'hDEADBEEF, 32'h00002000, 32'h1000,   32'h00003000};
    alu_v[12] = '{5'd12,    32'h12345678, 32'h11111111, 32'h0,      32'h00000000};

    mdu_v[0]  = '{OP_MUL,   32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 33, 32};
    mdu_v[1]  = '{OP_MULH,  32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 33, 32};
    mdu_v[2]  = '{OP_MULHU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 33, 32};
    mdu_v[3]  = '{OP_MULH,  32'h80000000, 32'h80000000, 32'h40000000, 33, 32};
    mdu_v[4]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33, 32};
    mdu_v[5]  = '{OP_REM,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33, 32};
    mdu_v[6]  = '{OP_DIVU,  32'd100,      32'd7,        32'd14,       33, 32};
    mdu_v[7]  = '{OP_REMU,  32'd100,      32'd7,        32'd2,        33, 32};
    mdu_v[8]  = '{OP_REM,   32'd7,        32'hFFFFFFFE, 32'd1,        33, 32};
    mdu_v[9]  = '{OP_DIV,   32'd5,        32'd0,        32'hFFFFFFFF, 1,  0};
    mdu_v[10] = '{OP_REM,   32'd9,        32'd0,        32'd9,        1,  0};
    mdu_v[11] = '{OP_DIVU,  32'd9,        32'd0,        32'hFFFFFFFF, 1,  0};
    mdu_v[12] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  0};
    mdu_v[13] = '{OP_REM,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1,  0};

    rst      = 1'b1;
    ex_valid = 1'b0;
    ex_pc    = '0;
    fwd_a    = '0;
    fwd_b    = '0;
    ex_aluop = OP_ADD;
    flush    = 1'b0;
    tick();
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_aluout", out_aluout, 32'd0);
    chk("reset out_zero", 32'(out_zero), 32'd0);
    chk("reset mdu_busy", 32'(mdu_busy), 32'd0);
    chk("reset ex_stall", 32'(ex_stall), 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 13; i++) begin
      ex_valid = 1'b1;
      ex_aluop = alu_v[i].op;
      fwd_a    = alu_v[i].a;
      fwd_b    = alu_v[i].b;
      ex_pc    = alu_v[i].pc;
      #1;
      chk($sformatf("alu[%0d] stall", i), 32'(ex_stall), 32'd0);
      tick();
      chk($sformatf("alu[%0d] valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("alu[%0d] result", i), out_aluout, alu_v[i].exp);
      chk($sformatf("alu[%0d] zero", i), 32'(out_zero), 32'(alu_v[i].exp == 32'd0));
    end
    ex_valid = 1'b0;
    tick();
    chk("alu valid one cycle", 32'(out_valid), 32'd0);
    chk("alu result holds", out_aluout, alu_v[12].exp);

    ex_valid = 1'b1;
    ex_aluop = OP_ADD;
    fwd_a    = 32'd1;
    fwd_b    = 32'd1;
    flush    = 1'b1;
    tick();
    chk("idle flush no valid", 32'(out_valid), 32'd0);
    ex_valid = 1'b0;
    flush    = 1'b0;

    for (int i = 0; i < 14; i++)
      run_mdu($sformatf("mdu[%0d]", i), mdu_v[i]);

    begin
      int seen;
      seen     = 0;
      ex_valid = 1'b1;
      ex_aluop = OP_DIVU;
      fwd_a    = 32'd100;
      fwd_b    = 32'd7;
      tick();
      ex_valid = 1'b0;
      for (int k = 0; k < 9; k++) begin
        tick();
        if (out_valid) seen++;
      end
      flush = 1'b1;
      #1;
      chk("flush stall drop", 32'(ex_stall), 32'd0);
      chk("flush busy before edge", 32'(mdu_busy), 32'd1);
      tick();
      flush = 1'b0;
      if (out_valid) seen++;
      chk("flush no out_valid", 32'(seen), 32'd0);
      chk("flush busy cleared", 32'(mdu_busy), 32'd0);
      ex_valid = 1'b1;
      ex_aluop = OP_ADD;
      fwd_a    = 32'd2;
      fwd_b    = 32'd3;
      tick();
      ex_valid = 1'b0;
      chk("post-flush add valid", 32'(out_valid), 32'd1);
      chk("post-flush add result", out_aluout, 32'd5);
      for (int k = 0; k < 3; k++) begin
        tick();
        if (out_valid) seen++;
      end
      chk("flushed div never completes", 32'(seen), 32'd0);
    end

    ex_valid = 1'b1;
    ex_aluop = OP_MUL;
    fwd_a    = 32'd3;
    fwd_b    = 32'd4;
    tick();
    ex_valid = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    #2;
    rst = 1'b1;
    #1;
    chk("async rst out_aluout", out_aluout, 32'd0);
    chk("async rst out_valid", 32'(out_valid), 32'd0);
    chk("async rst mdu_busy", 32'(mdu_busy), 32'd0);
    chk("async rst ex_stall", 32'(ex_stall), 32'd0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 35; k++) begin
      tick();
      if (out_valid) chk("no result after rst", 32'(out_valid), 32'd0);
    end
    ex_valid = 1'b1;
    ex_aluop = OP_SLT;
    fwd_a    = 32'hFFFFFFFF;
    fwd_b    = 32'd1;
    tick();
    ex_valid = 1'b0;
    chk("post-rst slt valid", 32'(out_valid), 32'd1);
    chk("post-rst slt result", out_aluout, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
